// File: rtl/imem_loader.sv
// Fills the instruction memory from a framed host byte stream and holds the CPU until the load verifies.
// Writes land one cycle after each word's fourth byte is accepted.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [7:0]            In_byte,
  input  logic                  In_valid,
  output logic                  In_ready,
  output logic                  Mem_we,
  output logic [ADDR_WIDTH-1:0] Mem_addr,
  output logic [DATA_WIDTH-1:0] Mem_wdata,
  output logic [ADDR_WIDTH:0]   Words_loaded,
  output logic                  Cpu_hold,
  output logic                  Done,
  output logic                  Error
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [1:0]              idx_q, idx_d;
  logic [23:0]             buf_q, buf_d;
  logic [7:0]              csum_q, csum_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     words_q, words_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                    in_ready;
  logic                    accept;
  logic                    last_word;
  logic [16:0]             n_words;

  assign accept    = In_valid && in_ready;
  // The word currently being assembled (or written) is the final one of the load.
  assign last_word = (17'(words_q) + 17'd1) == {1'b0, len_q};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    csum_d   = csum_q;
    addr_d   = addr_q;
    words_d  = words_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    in_ready = 1'b0;
    n_words  = '0;

    // Address and count advance at the end of the write cycle.
    if (we_q) begin
      addr_d  = addr_q + 1'b1;
      words_d = words_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_d = S_LEN_LO;
          len_d   = '0;
          idx_d   = '0;
          csum_d  = '0;
          addr_d  = '0;
          words_d = '0;
        end
      end

      S_LEN_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          len_d[7:0] = In_byte;
          state_d    = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        in_ready = 1'b1;
        n_words  = {1'b0, In_byte, len_q[7:0]};
        if (accept) begin
          len_d[15:8] = In_byte;
          if (n_words > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (n_words == 17'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        // During the final write the next byte is the checksum, which CHECK must take.
        in_ready = !(we_q && last_word);
        if (we_q && last_word) begin
          state_d = S_CHECK;
        end
        if (accept) begin
          csum_d = csum_q ^ In_byte;
          idx_d  = idx_q + 2'd1;
          case (idx_q)
            2'd0: buf_d[7:0]   = In_byte;
            2'd1: buf_d[15:8]  = In_byte;
            2'd2: buf_d[23:16] = In_byte;
            default: begin
              we_d    = 1'b1;
              wdata_d = DATA_WIDTH'({In_byte, buf_q});
            end
          endcase
        end
      end

      S_CHECK: begin
        in_ready = 1'b1;
        if (accept) begin
          state_d = (In_byte == csum_q) ? S_DONE : S_ERROR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign In_ready     = in_ready;
  assign Mem_we       = we_q;
  assign Mem_addr     = addr_q;
  assign Mem_wdata    = wdata_q;
  assign Words_loaded = words_q;
  assign Done         = (state_q == S_DONE);
  assign Error        = (state_q == S_ERROR);
  assign Cpu_hold     = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of framed streams plus hand-written multi-cycle sequences,
// memory writes checked against a queue of expected (address, data) pairs.
module tb_imem_loader;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [7:0]  In_byte;
  logic        In_valid;
  logic        In_ready;
  logic        Mem_we;
  logic [7:0]  Mem_addr;
  logic [31:0] Mem_wdata;
  logic [8:0]  Words_loaded;
  logic        Cpu_hold;
  logic        Done;
  logic        Error;

  imem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .In_byte(In_byte), .In_valid(In_valid), .In_ready(In_ready),
    .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
    .Words_loaded(Words_loaded), .Cpu_hold(Cpu_hold),
    .Done(Done), .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          nb;
    logic [95:0] bytes;   // first stream byte in the top octet
    bit          gap;
    int          start_mid;
    bit          exp_done;
    bit          exp_err;
    int          exp_wl;
  } vec_t;

  wr_t        exp_q[$];
  logic [7:0] stream[$];
  vec_t       tbl[9];
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected write: addr 0x%0h data 0x%0h, want no write", Mem_addr, Mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write addr", 32'(Mem_addr), 32'(e.addr));
        chk("write data", Mem_wdata, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    idle(1);
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok       = 1'b0;
    In_byte  = b;
    In_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge Clk);
      if (In_ready) begin
        @(posedge Clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    In_valid = 1'b0;
  endtask

  // Sends the queued stream; expected writes are derived from the stream itself.
  task automatic run_stream(input bit gap, input int start_mid);
    int          n_words;
    logic [31:0] w;
    bit          ok;
    n_words = 0;
    w       = '0;
    pulse_start();
    for (int k = 0; k < stream.size(); k++) begin
      if (k == start_mid) pulse_start();
      if (gap) idle($urandom_range(3, 0));
      if (k == 1) n_words = int'({stream[1], stream[0]});
      if (k >= 2 && n_words <= 256 && k < 2 + 4 * n_words) begin
        int j;
        j = k - 2;
        w[8 * (j % 4) +: 8] = stream[k];
        if (j % 4 == 3) exp_q.push_back('{addr: 8'(j / 4), data: w});
      end
      send_byte(stream[k], ok);
      if (!ok) begin
        n_vec++;
        n_bad++;
        $display("FAIL byte %0d not accepted: In_ready stayed 0, want accept", k);
        break;
      end
    end
  endtask

  task automatic check_end(input string tag, input bit d, input bit e, input int wl);
    @(negedge Clk);
    chk({tag, " Done"}, 32'(Done), 32'(d));
    chk({tag, " Error"}, 32'(Error), 32'(e));
    chk({tag, " Cpu_hold"}, 32'(Cpu_hold), 32'(!d));
    chk({tag, " Words_loaded"}, 32'(Words_loaded), 32'(wl));
    chk({tag, " In_ready"}, 32'(In_ready), 32'd0);
    chk({tag, " pending writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic vec_t mkv(input int nb, input logic [95:0] b, input bit gap, input int sm,
                               input bit d, input bit e, input int wl);
    vec_t v;
    v.nb = nb; v.bytes = b; v.gap = gap; v.start_mid = sm;
    v.exp_done = d; v.exp_err = e; v.exp_wl = wl;
    return v;
  endfunction

  initial begin
    logic [7:0] x;
    bit         ok;

    tbl[0] = mkv(11, 96'h02_00_13_00_00_00_93_00_10_00_90_00, 0, -1, 1, 0, 2);
    tbl[1] = mkv(11, 96'h02_00_13_00_00_00_93_00_10_00_91_00, 0, -1, 0, 1, 2);
    tbl[2] = mkv(11, 96'h02_00_13_00_00_00_93_00_10_00_90_00, 0, -1, 1, 0, 2);
    tbl[3] = mkv(11, 96'h02_00_13_00_00_00_93_00_10_00_90_00, 1, -1, 1, 0, 2);
    tbl[4] = mkv(11, 96'h02_00_13_00_00_00_93_00_10_00_90_00, 0,  8, 1, 0, 2);
    tbl[5] = mkv( 3, 96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, -1, 1, 0, 0);
    tbl[6] = mkv( 3, 96'h00_00_01_00_00_00_00_00_00_00_00_00, 0, -1, 0, 1, 0);
    tbl[7] = mkv( 2, 96'h01_01_00_00_00_00_00_00_00_00_00_00, 0, -1, 0, 1, 0);
    tbl[8] = mkv( 7, 96'h01_00_AA_BB_CC_DD_00_00_00_00_00_00, 0, -1, 1, 0, 1);

    Start    = 1'b0;
    In_valid = 1'b0;
    In_byte  = 8'h00;
    Rst_n    = 1'b0;
    #3;
    chk("reset In_ready", 32'(In_ready), 32'd0);
    chk("reset Mem_we", 32'(Mem_we), 32'd0);
    chk("reset Mem_addr", 32'(Mem_addr), 32'd0);
    chk("reset Mem_wdata", Mem_wdata, 32'd0);
    chk("reset Words_loaded", 32'(Words_loaded), 32'd0);
    chk("reset Cpu_hold", 32'(Cpu_hold), 32'd1);
    chk("reset Done", 32'(Done), 32'd0);
    chk("reset Error", 32'(Error), 32'd0);
    idle(2);
    Rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 9; i++) begin
      stream.delete();
      for (int k = 0; k < tbl[i].nb; k++) stream.push_back(tbl[i].bytes[95 - 8 * k -: 8]);
      run_stream(tbl[i].gap, tbl[i].start_mid);
      check_end($sformatf("vec%0d", i), tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_wl);
      idle(2);
    end

    // Full-capacity load: last write at address 255, count reaches 256.
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h01);
    x = 8'h00;
    for (int k = 0; k < 1024; k++) begin
      logic [7:0] r;
      r = 8'($urandom_range(255, 0));
      x ^= r;
      stream.push_back(r);
    end
    stream.push_back(x);
    run_stream(0, -1);
    check_end("full", 1'b1, 1'b0, 256);
    idle(2);

    // Reset in the middle of a word: nothing written, everything back to reset values.
    pulse_start();
    send_byte(8'h02, ok);
    send_byte(8'h00, ok);
    send_byte(8'h13, ok);
    send_byte(8'h00, ok);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midrst Cpu_hold", 32'(Cpu_hold), 32'd1);
    chk("midrst Done", 32'(Done), 32'd0);
    chk("midrst Error", 32'(Error), 32'd0);
    chk("midrst In_ready", 32'(In_ready), 32'd0);
    chk("midrst Mem_addr", 32'(Mem_addr), 32'd0);
    chk("midrst Mem_wdata", Mem_wdata, 32'd0);
    chk("midrst Words_loaded", 32'(Words_loaded), 32'd0);
    idle(2);
    Rst_n = 1'b1;
    In_valid = 1'b1;
    In_byte  = 8'h00;
    idle(6);
    @(negedge Clk);
    chk("postrst In_ready", 32'(In_ready), 32'd0);
    chk("postrst Cpu_hold", 32'(Cpu_hold), 32'd1);
    In_valid = 1'b0;
    idle(2);
    chk("postrst pending writes", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the single-cycle processor's instruction memory. The processor fetches from this memory; this block fills it.
- Accepts a byte stream (valid/ready) from the host link and assembles little-endian 32-bit words.
- Writes the words sequentially into instruction memory starting at word address 0, then checks an XOR checksum.
- Holds the processor (Cpu_hold) until a load completes successfully.

Parameters:
ADDR_WIDTH, 8, instruction memory word-address width (capacity 2^ADDR_WIDTH words)
DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Start  input  1  pulse: begin a new load (honoured only in IDLE, DONE, ERROR)
In_byte  input  8  incoming stream byte
In_valid  input  1  In_byte valid
In_ready  output  1  loader can accept a byte this cycle
Mem_we  output  1  instruction memory write strobe, one cycle per word
Mem_addr  output  ADDR_WIDTH  word write address
Mem_wdata  output  32  word write data
Words_loaded  output  ADDR_WIDTH+1  count of words written in current load
Cpu_hold  output  1  1 = processor held (PC frozen / kept in reset)
Done  output  1  level: last load succeeded
Error  output  1  level: last load failed (length or checksum)

Behaviour:
- Reset (async, Rst_n=0):
  - State=IDLE; In_ready=0, Mem_we=0, Mem_addr=0, Mem_wdata=0, Words_loaded=0.
  - Cpu_hold=1, Done=0, Error=0. Checksum, length and byte index are cleared.
- Byte transfer happens when In_valid && In_ready at a rising edge. In_ready=1 only in LEN_LO, LEN_HI, DATA, CHECK. In_valid may drop between bytes with no effect.
- Stream format: LEN_LO, LEN_HI (N words, 16-bit LE), then 4N data bytes, LSB first per word, then one checksum byte equal to the XOR of all 4N data bytes.
- States and transitions:
  - IDLE: Start -> LEN_LO. Clears Done, Error, Words_loaded, checksum and Mem_addr. Cpu_hold=1.
  - LEN_LO: on accepted byte -> LEN_HI.
  - LEN_HI: on accepted byte, evaluate N:
    - N > 2^ADDR_WIDTH -> ERROR.
    - N == 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: each accepted byte is shifted into the word buffer at byte index 0..3 and XORed into the checksum.
    - On byte index 3: next cycle Mem_we=1 for exactly one cycle, Mem_wdata = assembled word, Mem_addr = current address.
    - Address and Words_loaded increment after the write.
    - When Words_loaded reaches N -> CHECK.
    - Byte acceptance continues during the Mem_we cycle; the memory is always ready.
  - CHECK: on accepted byte:
    - byte == checksum -> DONE.
    - otherwise -> ERROR.
  - DONE: Done=1, Cpu_hold=0 from the cycle after the checksum byte is accepted. Start -> LEN_LO, reasserting Cpu_hold and clearing Done in the same edge.
  - ERROR: Error=1, Cpu_hold=1. Start -> LEN_LO.
- Start is ignored in LEN_LO, LEN_HI, DATA and CHECK.
- Mem_addr wrap: with N == 2^ADDR_WIDTH, the last write uses address 2^ADDR_WIDTH-1. Words_loaded is ADDR_WIDTH+1 bits and reads N with no overflow. The address register may wrap to 0 afterwards.
- Reset mid-load: immediate abort. Memory contents are left as partially written; Cpu_hold=1.
- No write ever occurs in IDLE, LEN_*, CHECK, DONE or ERROR.

Test Plan:
- Normal load: Start; stream 02 00 | 13 00 00 00 | 93 00 10 00 | 90.
  - Expected writes: (addr 0, 0x00000013), (addr 1, 0x00100093), each Mem_we exactly 1 cycle.
  - Then Done=1, Cpu_hold=0, Words_loaded=2.
- Bad checksum: same stream with final byte 91 -> both writes occur, then Error=1, Done=0, Cpu_hold=1. A new Start plus the correct stream -> Done=1.
- Zero length: Start; 00 00 00 -> no Mem_we, Done=1, Cpu_hold=0. Zero length with checksum 01 -> Error=1.
- Oversize (ADDR_WIDTH=8): Start; 01 01 (N=257) -> Error=1 right after LEN_HI, In_ready=0, no writes.
- Gapped stream and reset: normal load with In_valid low 0-3 random cycles between bytes -> identical writes and Done.
  - Then Start, send 02 00 13 00 and pulse Rst_n=0 -> all outputs at reset values, Cpu_hold=1, no further writes.
- Start while busy: pulse Start during DATA -> ignored; the load completes normally with unchanged addresses.
